instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control decoder. Owns the PC, fetches 32-bit instructions from a variable-latency instruction memory over a req/ack handshake, and holds each instruction stable in an instruction register. Presents the decoder fields (op, funct3, funct7) until the core retires the instruction. Computes the next PC from the decoder's PCSrc and the datapath's branch/jump target; flags misaligned targets and memory timeouts.

---
 rtl/rv_fetch_pkg.sv | 27 ++
 rtl/fetch_timeout_ctr.sv | 31 +++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/NOP constants and
// instruction field bit positions (also used by the control decoder).
package rv_fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // ADDI x0,x0,0
    localparam int unsigned     TIMEOUT_DEFAULT   = 16;

    // Instruction field bit positions
    localparam int unsigned OP_LSB       = 0;
    localparam int unsigned OP_MSB       = 6;
    localparam int unsigned FUNCT3_LSB   = 12;
    localparam int unsigned FUNCT3_MSB   = 14;
    localparam int unsigned FUNCT7B5_BIT = 30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles an outstanding fetch has waited for ack.
// Ports: clk, reset_n (sync, active-low), i_clear, i_enable,
//        o_expired_c (combinational: count has reached TIMEOUT-1).
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Clear dominates enable; counter never needs to wrap past TIMEOUT-1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired_c = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches instructions over a req/ack handshake,
// holds them in an instruction register until retired, computes next PC.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   imem_req/addr/ack/rdata      instruction memory handshake
//   instr_valid, instr, pc       registered instruction state
//   op, funct3, funct7, pc_plus4 combinational views of the registers
//   retire, pc_src, pc_target    retirement and redirect from the core
//   fetch_err, misalign_err      sticky error flags (cleared only by reset)
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0]  RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned  TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [31:0]  NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [OP_W-1:0]   op,
    output logic [F3_W-1:0]   funct3,
    output logic              funct7,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    input  logic              retire,
    input  logic              pc_src,
    input  logic [XLEN-1:0]   pc_target,
    output logic              fetch_err,
    output logic              misalign_err
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic            r_fetch_err;
    logic            r_misalign_err;

    logic [XLEN-1:0] w_pc_plus4;
    logic            w_in_fetch;
    logic            w_expired;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_in_fetch = (r_state == S_FETCH);

    // Counter runs only while a request is outstanding and unanswered
    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (!w_in_fetch || imem_ack),
        .i_enable    (w_in_fetch),
        .o_expired_c (w_expired)
    );

    // Fetch FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_imem_req     <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_fetch_err    <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    // Ack wins over a timeout expiring in the same cycle
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_EXEC;
                    end else if (w_expired) begin
                        r_fetch_err <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_state     <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (retire) begin
                        r_instr_valid <= 1'b0;
                        r_instr       <= NOP_INSTR;
                        if (!pc_src) begin
                            r_pc       <= w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else if (pc_target[1:0] == 2'b00) begin
                            r_pc       <= pc_target;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_misalign_err <= 1'b1;
                            r_state        <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc;
    assign instr_valid  = r_instr_valid;
    assign instr        = r_instr;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign fetch_err    = r_fetch_err;
    assign misalign_err = r_misalign_err;

    assign op     = r_instr[OP_MSB:OP_LSB];
    assign funct3 = r_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7 = r_instr[FUNCT7B5_BIT];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        fetch_err;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .retire       (retire),
        .pc_src       (pc_src),
        .pc_target    (pc_target),
        .fetch_err    (fetch_err),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle for sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        retire = 1'b0; pc_src = 1'b0; pc_target = '0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", instr, NOP); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h exp 4", pc_plus4); end
        checks++; if ({fetch_err, misalign_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b exp 00", {fetch_err, misalign_err}); end
    endtask

    task automatic test_zero_wait();
        reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req_edge1: got %b exp 1", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_edge1: got %b exp 0", instr_valid); end
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid_edge2: got %b exp 1", instr_valid); end
        checks++; if (op !== 7'b0110011) begin errors++; $display("FAIL zw_op: got %b exp 0110011", op); end
        checks++; if ({funct3, funct7} !== 4'b0000) begin errors++; $display("FAIL zw_funct: got %b exp 0000", {funct3, funct7}); end
        checks++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin errors++; $display("FAIL zw_pc: got %h/%h exp 0/4", pc, pc_plus4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_drop: got %b exp 0", imem_req); end
        // Hold without retire
        tick(); tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0033) begin errors++; $display("FAIL zw_hold: got %b/%h exp 1/00000033", instr_valid, instr); end
    endtask

    task automatic test_latency();
        retire = 1'b1; pc_src = 1'b0;
        tick();
        retire = 1'b0; imem_rdata = 32'h4000_0033;
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL lat_retire: got %b/%h exp 0/%h", instr_valid, instr, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL lat_req0: got %b/%h exp 1/4", imem_req, imem_addr); end
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++; $display("FAIL lat_hold%0d: got %b/%h/%b exp 1/4/0", i, imem_req, imem_addr, instr_valid); end
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h4000_0033) begin errors++; $display("FAIL lat_instr: got %b/%h exp 1/40000033", instr_valid, instr); end
        checks++; if (funct7 !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL lat_f7_pc: got %b/%h exp 1/4", funct7, pc); end
    endtask

    task automatic test_branch();
        retire = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0100;
        tick();
        retire = 1'b0; pc_src = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %b/%h exp 1/100", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0020_9063;
        tick();
        imem_ack = 1'b0;
        checks++; if (op !== 7'h63 || funct3 !== 3'd1 || funct7 !== 1'b0) begin errors++; $display("FAIL br_fields: got %h/%0d/%b exp 63/1/0", op, funct3, funct7); end
        checks++; if (pc !== 32'h100 || pc_plus4 !== 32'h104) begin errors++; $display("FAIL br_pc: got %h/%h exp 100/104", pc, pc_plus4); end
    endtask

    task automatic test_misalign();
        retire = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0102;
        tick();
        checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b/%b exp 1/0", misalign_err, imem_req); end
        checks++; if (pc !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_pc: got %h/%b exp 100/0", pc, instr_valid); end
        // Halted: retire and ack must be ignored
        pc_src = 1'b0; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h100 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_halt%0d: got req=%b v=%b pc=%h err=%b", i, imem_req, instr_valid, pc, misalign_err); end
        end
        retire = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        checks++; if (misalign_err !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL to_reset: got %b/%h exp 0/0", misalign_err, pc); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL to_req_rise: got %b exp 1", imem_req); end
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got req=%b err=%b exp 1/0", k, imem_req, fetch_err); end
        end
        tick();
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL to_expire: got err=%b req=%b exp 1/0", fetch_err, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick(); tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== NOP || fetch_err !== 1'b1) begin errors++; $display("FAIL to_late_ack: got v=%b i=%h err=%b", instr_valid, instr, fetch_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL wr_reset_err: got %b exp 0", fetch_err); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick(); tick();
        imem_ack = 1'b0;
        retire = 1'b1; pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
        tick();
        retire = 1'b0; pc_src = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr_top: got %h exp fffffffc", imem_addr); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wr_plus4: got %h/%h exp fffffffc/0", pc, pc_plus4); end
        retire = 1'b1; pc_src = 1'b0;
        tick();
        retire = 1'b0;
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wr_wrap: got pc=%h addr=%h req=%b exp 0/0/1", pc, imem_addr, imem_req); end
    endtask

    task automatic test_reset_mid_fetch();
        // Move to a non-reset pc first so the reset is observable on pc
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        retire = 1'b1; pc_src = 1'b0;
        tick();
        retire = 1'b0;
        checks++; if (imem_req !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL rm_pre: got req=%b pc=%h exp 1/4", imem_req, pc); end
        reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (instr !== NOP || instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_reset: got i=%h v=%b pc=%h req=%b", instr, instr_valid, pc, imem_req); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL rm_restart: got req=%b v=%b i=%h exp 1/0/%h", imem_req, instr_valid, instr, NOP); end
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF || pc !== 32'h0) begin errors++; $display("FAIL rm_fetch: got v=%b i=%h pc=%h exp 1/deadbeef/0", instr_valid, instr, pc); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_branch();
        test_misalign();
        test_timeout();
        test_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
